// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit for the E stage.
// Accepts one mult/multu/div/divu per Start pulse and holds Busy for a fixed
// number of cycles before committing the result to HI/LO. The unit also
// services mthi/mtlo writes and mfhi/mflo reads.
//
// Handshake: Start is a one-cycle issue pulse and is accepted only in IDLE
// with MDOp in 1..4. Busy is high for exactly N cycles after the issue edge,
// and HI/LO commit on the edge where Busy falls. Anything presented while
// Busy is high is ignored, so a stray Start cannot corrupt an operation in
// flight.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    // Datapath signals derived from the latched operands.
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        is_signed_div;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;
    logic        issue;

    // The low 64 bits of a product of sign-extended operands equal the
    // signed 64-bit product, so one multiplier shape serves mult.
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division runs on magnitudes and fixes signs afterwards. This
    // also yields the required 0x80000000 / -1 = 0x80000000, remainder 0.
    assign is_signed_div = (op_q == OP_DIV);
    assign abs_a = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign div_n = is_signed_div ? abs_a : a_q;
    assign div_d = is_signed_div ? abs_b : b_q;

    // Divider shared by div and divu; its value is unused when the divisor is zero.
    always_comb begin
        quo_u = '0;
        rem_u = '0;
        if (div_d != 32'd0) begin
            quo_u = div_n / div_d;
            rem_u = div_n % div_d;
        end
    end

    // Select the value to commit and whether a commit happens at all.
    always_comb begin
        res_hi = HI;
        res_lo = LO;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_we = 1'b1;
            end
            OP_DIV: begin
                res_lo = (a_q[31] ^ b_q[31]) ? (~quo_u + 32'd1) : quo_u;
                res_hi = a_q[31] ? (~rem_u + 32'd1) : rem_u;
                res_we = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_lo = quo_u;
                res_hi = rem_u;
                res_we = (b_q != 32'd0);
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    assign issue = Start && ((MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                             (MDOp == OP_DIV)  || (MDOp == OP_DIVU));

    // Sequencing FSM: issue, countdown, commit, plus mthi/mtlo while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_q  <= MDOp;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= ((MDOp == OP_MULT) || (MDOp == OP_MULTU)) ?
                                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        Busy  <= 1'b1;
                        state <= S_BUSY;
                    end else if (MDOp == OP_MTHI) begin
                        HI <= A;
                    end else if (MDOp == OP_MTLO) begin
                        LO <= A;
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        if (res_we) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read port: zero-latency view of the architectural HI/LO.
    always_comb begin
        MDOut = '0;
        case (MDOp)
            OP_MFHI: MDOut = HI;
            OP_MFLO: MDOut = LO;
            default: MDOut = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a behavioural HI/LO model
// compared every cycle, plus literal expectations for the main cases.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard tally
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    // Behavioural model: architectural HI/LO and remaining busy cycles.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi, m_plo;
    bit          m_pwe;
    int          m_left = 0;

    always @(posedge clk) begin
        longint sa, sb;
        logic [63:0] p;
        if (!reset) begin
            m_hi = '0;
            m_lo = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwe) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (Start && MDOp >= 4'd1 && MDOp <= 4'd4) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            m_pwe = 1;
            case (MDOp)
                4'd1: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; end
                4'd2: begin p = {32'd0, A} * {32'd0, B}; m_phi = p[63:32]; m_plo = p[31:0]; end
                4'd3: begin
                    if (B == 0) m_pwe = 0;
                    else begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
                end
                default: begin
                    if (B == 0) m_pwe = 0;
                    else begin m_plo = A / B; m_phi = A % B; end
                end
            endcase
            m_left = (MDOp <= 4'd2) ? MULT_N : DIV_N;
        end else if (MDOp == 4'd7) begin
            m_hi = A;
        end else if (MDOp == 4'd8) begin
            m_lo = A;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
            check("cyc_hi", HI, m_hi);
            check("cyc_lo", LO, m_lo);
            check("cyc_mdout", MDOut, (MDOp == 4'd5) ? m_hi : (MDOp == 4'd6) ? m_lo : 32'd0);
        end
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 1'b0;
        MDOp  = 4'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Issue one operation, measure the busy window, then pin HI/LO literally.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int busy_cycles;
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        tick();
        idle_inputs();
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Busy) busy_cycles++;
            else break;
        end
        tick();
        check({name, "_busy_len"}, 32'(busy_cycles), 32'(n));
        check({name, "_hi"}, HI, ehi);
        check({name, "_lo"}, LO, elo);
        MDOp = 4'd5;
        #1;
        check({name, "_mfhi"}, MDOut, ehi);
        MDOp = 4'd6;
        #1;
        check({name, "_mflo"}, MDOut, elo);
        tick();
        MDOp = 4'd0;
    endtask

    // Directed stimulus
    initial begin
        reset = 1'b0;
        idle_inputs();
        tick();
        chk_en = 1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Reset state
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        MDOp = 4'd5; #1;
        check("rst_mfhi", MDOut, 32'd0);
        MDOp = 4'd6; #1;
        check("rst_mflo", MDOut, 32'd0);
        tick();
        MDOp = 4'd0;

        // Main function
        run_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, MULT_N, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_nb", 4'd3, 32'd7, 32'hFFFFFFFE, DIV_N, 32'h00000001, 32'hFFFFFFFD);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h00000000, 32'h80000000);
        run_op("divu",  4'd4, 32'hFFFFFFFF, 32'd10, DIV_N, 32'h00000005, 32'h19999999);

        // Start with a non-md opcode is ignored
        Start = 1'b1; MDOp = 4'd5; A = 32'd1; B = 32'd1;
        tick();
        idle_inputs();
        check("start_nonmd_busy", {31'd0, Busy}, 32'd0);

        // Stray Start and mthi during busy must not disturb the multu
        Start = 1'b1; MDOp = 4'd2; A = 32'h00010000; B = 32'h00010000;
        tick();
        idle_inputs();
        tick();
        Start = 1'b1; MDOp = 4'd3; A = 32'd9; B = 32'd2;
        tick();
        Start = 1'b0; MDOp = 4'd7; A = 32'hDEAD;
        tick();
        idle_inputs();
        repeat (4) tick();
        check("stray_busy_end", {31'd0, Busy}, 32'd0);
        check("stray_hi", HI, 32'h00000001);
        check("stray_lo", LO, 32'h00000000);

        // mthi / mtlo, then divide by zero retains them
        MDOp = 4'd7; A = 32'h1234;
        tick();
        MDOp = 4'd8; A = 32'h5678;
        tick();
        MDOp = 4'd5; #1;
        check("mthi_read", MDOut, 32'h1234);
        tick();
        run_op("divu0", 4'd4, 32'd7, 32'd0, DIV_N, 32'h1234, 32'h5678);

        // Reset during an in-flight divide aborts it
        Start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (15) tick();
        check("abort_nocommit_hi", HI, 32'd0);
        check("abort_nocommit_lo", LO, 32'd0);
        run_op("mult_after", 4'd1, 32'd6, 32'd7, MULT_N, 32'd0, 32'd42);

        // Reset wins over a simultaneous Start
        reset = 1'b0; Start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd3;
        tick();
        reset = 1'b1;
        idle_inputs();
        check("rst_vs_start_busy", {31'd0, Busy}, 32'd0);
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide unit with sequencing controller for the E stage of the five-stage MIPS pipeline. Accepts one mult/multu/div/divu per `Start` pulse, holds `Busy` for a fixed number of cycles, then commits the result to HI/LO. It also services mthi/mtlo writes and mfhi/mflo reads. `Start` and `Busy` feed the hazard unit, which stalls any multiply/divide-class instruction in D while either is high.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: `Busy` duration for mult/multu.
- `DIV_CYCLES`, default 10: `Busy` duration for div/divu.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Reset is synchronous and active-low: state resets on a rising `clk` edge while `reset` == 0.
- `Start`  in  1  Issue pulse from E, high for one cycle with a mult/multu/div/divu `MDOp`.
- `MDOp`  in  4  Operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo. Codes 9-15 are treated as none.
- `A`  in  32  rs operand, already forwarded.
- `B`  in  32  rt operand, already forwarded.
- `Busy`  out  1  Operation in progress (registered).
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `MDOut`  out  32  Read data for mfhi/mflo (combinational).

## Operation
States:
- IDLE: `Busy` = 0.
- BUSY: `Busy` = 1, countdown register `cnt` running.

Issue:
- In IDLE with `Start` = 1 and `MDOp` in 1..4:
  - Latch `A`, `B` and `MDOp`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to BUSY.
- `Start` with `MDOp` outside 1..4 is ignored.
- `Start` while in BUSY is ignored. The hazard unit guarantees this cannot happen; the block must not corrupt state if it does.

Countdown:
- In BUSY, `cnt` decrements each cycle.
- On the edge where `cnt` == 1: commit HI/LO, set `cnt` to 0, return to IDLE.

Results:
- mult: {HI,LO} = signed 64-bit product of A and B.
- multu: {HI,LO} = unsigned 64-bit product of A and B.
- div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- div with A = 0x80000000, B = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- divu: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (B = 0): the operation still takes `DIV_CYCLES` with `Busy` high, but HI and LO are left unchanged.
- Result computation method (at issue or iterative) is free, provided committed values and timing match this spec.

mthi/mtlo:
- In IDLE, `MDOp` = 7 writes HI <= A and `MDOp` = 8 writes LO <= A on the same edge. `Start` is not required.
- Ignored in BUSY; the hazard unit prevents this case.

Reads:
- `MDOut` = HI when `MDOp` = 5, LO when `MDOp` = 6, otherwise 0.
- Reads show the current register values. There is no bypass of an uncommitted result.

Reset:
- `reset` low forces IDLE, `cnt` = 0, `Busy` = 0, HI = 0, LO = 0.
- An operation in progress is aborted and never commits.
- `MDOut` is therefore 0 after reset.

## Timing
- `Start` sampled high at edge t: `Busy` is high from edge t through edge t+N, i.e. exactly N cycles, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO update at edge t+N, the same edge at which `Busy` falls.
- A new `Start` is accepted at edge t+N+1 at the earliest. The hazard unit enforces this, because `Start` | `Busy` covers the issue cycle plus N busy cycles.
- mthi/mtlo: HI/LO update at the edge where `MDOp` is sampled. The new value appears on `MDOut` the following cycle.
- `MDOut` has zero latency from `MDOp`, HI and LO.
- Simultaneous `reset` = 0 and `Start` = 1: reset wins, nothing is issued.
- Minimum legal parameter value is 1. With N = 1, `Busy` is high for one cycle.

## Test plan
- Reset, then idle: `Busy` = 0, HI = LO = 0, `MDOut` = 0 for mfhi and for mflo.
- mult, A = 0xFFFFFFFE (-2), B = 3:
  - `Busy` high exactly 5 cycles.
  - Afterwards HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - HI/LO unchanged while `Busy` is high.
- multu, same operands: HI = 0x00000002, LO = 0xFFFFFFFA.
- div, A = -7, B = 2: `Busy` high exactly 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- divu, A = 7, B = 0, after a preceding mthi 0x1234 / mtlo 0x5678:
  - `Busy` high 10 cycles.
  - HI = 0x1234 and LO = 0x5678 retained.
  - mfhi returns 0x1234.
- Start div, then pull `reset` low at the 4th busy cycle:
  - `Busy` = 0 and HI = LO = 0 on the next edge.
  - No later commit.
  - A fresh mult issued afterwards completes normally.
